// File: rtl/sram_ctrl.sv
// 32-bit load/store port onto a 16-bit async SRAM, split into LO then HI half-word phases.
// Latency 2*SRAM_WAIT+3 cycles per access; ready low stalls the requester until the DONE cycle.
module sram_ctrl #(
    parameter int unsigned SRAM_WAIT = 1,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N
);

    localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [16:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        phase_last;
    logic        dq_oe;
    logic [15:0] dq_out;

    assign read_data = rdata_q;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

    always_comb begin : next_state
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        phase_last = (cnt_q == WAIT_LAST);
        case (state_q)
            IDLE: begin
                if (rd_en | wr_en) begin
                    state_d = LO;
                    cnt_d   = 3'd0;
                    // a simultaneous read+write request is serviced as a write
                    op_wr_d = wr_en;
                    waddr_d = 17'((address - BASE_ADDR) >> 2);
                    wdata_d = write_data;
                end
            end
            LO: begin
                if (phase_last) begin
                    state_d = HI;
                    cnt_d   = 3'd0;
                    if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HI: begin
                if (phase_last) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                    if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : pin_drive
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];
        ready     = 1'b0;
        case (state_q)
            IDLE: ready = ~rd_en & ~wr_en;
            LO: begin
                SRAM_ADDR = {waddr_q, 1'b0};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
            end
            HI: begin
                SRAM_ADDR = {waddr_q, 1'b1};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
                dq_out    = wdata_q[31:16];
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            op_wr_q <= 1'b0;
            waddr_q <= 17'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
